// File: rtl/enokida_mem_pkg.sv
// rtl/enokida_mem_pkg.sv - shared types and constants for the memory responder
//   Holds the responder FSM state enum and the width of the grant-delay and
//   latency counters.
package enokida_mem_pkg;

  // Wide enough for GNT_DELAY and READ_LATENCY in the range 0..15.
  localparam int unsigned DLY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/enokida_mem_responder_if.sv
// rtl/enokida_mem_responder_if.sv - RI5CY-style data port bundle
//   master : initiator side (drives req/addr/we/be/wdata, receives gnt/rvalid/rdata)
//   slave  : responder side (the mirror image)
interface enokida_mem_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                    data_req_i;
  logic [ADDR_WIDTH-1:0]   data_addr_i;
  logic                    data_we_i;
  logic [DATA_WIDTH/8-1:0] data_be_i;
  logic [DATA_WIDTH-1:0]   data_wdata_i;
  logic                    data_gnt_o;
  logic                    data_rvalid_o;
  logic [DATA_WIDTH-1:0]   data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface

// File: rtl/enokida_be_ram.sv
// rtl/enokida_be_ram.sv - word-addressed backing store with byte-lane writes
//   clk     : write clock
//   we_i    : write strobe, be_i selects the byte lanes written
//   addr_i  : word index, shared by read and write
//   wdata_i : write data
//   rdata_o : word currently stored at addr_i (combinational read)
module enokida_be_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [WORDS_LOG2-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  localparam int NB = DATA_WIDTH / 8;

  // Contents are deliberately not reset so they survive a responder reset.
  logic [DATA_WIDTH-1:0] mem [2**WORDS_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/enokida_mem_responder.sv
// rtl/enokida_mem_responder.sv - single-outstanding memory responder for a RI5CY data port
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : req/addr/we/be/wdata in, gnt/rvalid/rdata out
//   read_count_o    : number of granted reads (wraps)
//   write_count_o   : number of granted writes (wraps)
module enokida_mem_responder
  import enokida_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int GNT_DELAY      = 0,
  parameter int READ_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  enokida_mem_responder_if.slave  bus,
  output logic [31:0]             read_count_o,
  output logic [31:0]             write_count_o
);

  localparam logic [DLY_W-1:0] GNT_DLY  = DLY_W'(GNT_DELAY);
  // BUSY covers cycles G+1 .. G+READ_LATENCY-1, so the countdown starts at L-2.
  localparam logic [DLY_W-1:0] LAT_LOAD = DLY_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  state_e                  state_q,  state_d;
  logic [DLY_W-1:0]        gcnt_q,   gcnt_d;
  logic [DLY_W-1:0]        lcnt_q,   lcnt_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
  logic [DATA_WIDTH-1:0]   hold_q,   hold_d;
  logic [31:0]             rd_cnt_q, rd_cnt_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;

  logic                    gnt;
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic                    addr_unused;

  // Byte offset and bits above the store depth are ignored, so addresses wrap.
  assign word_idx    = bus.data_addr_i[MEM_WORDS_LOG2+1:2];
  assign addr_unused = ^bus.data_addr_i;

  enokida_be_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS_LOG2 (MEM_WORDS_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (gnt & bus.data_we_i),
    .addr_i  (word_idx),
    .be_i    (bus.data_be_i),
    .wdata_i (bus.data_wdata_i),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    lcnt_d   = lcnt_q;
    hold_d   = hold_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;

    // rst_n gating keeps gnt low during reset even while req is high.
    gnt = rst_n && bus.data_req_i && (state_q != ST_BUSY) && (gcnt_q == GNT_DLY);

    case (state_q)
      ST_BUSY: begin
        gcnt_d = '0;
        if (lcnt_q == '0) state_d = ST_RESP;
        else              lcnt_d  = lcnt_q - 1'b1;
      end
      default: begin
        // IDLE and RESP both count req-high cycles toward the next grant.
        gcnt_d  = bus.data_req_i ? gcnt_q + 1'b1 : '0;
        state_d = ST_IDLE;
      end
    endcase

    if (gnt) begin
      gcnt_d = '0;
      // Read data is captured here so later writes cannot disturb the response.
      hold_d = bus.data_we_i ? '0 : ram_rdata;
      if (READ_LATENCY == 1) begin
        state_d = ST_RESP;
      end else begin
        state_d = ST_BUSY;
        lcnt_d  = LAT_LOAD;
      end
      if (bus.data_we_i) wr_cnt_d = wr_cnt_q + 32'd1;
      else               rd_cnt_d = rd_cnt_q + 32'd1;
    end

    // Registered outputs: rvalid/rdata follow the state being entered.
    rvalid_d = (state_d == ST_RESP);
    rdata_d  = rvalid_d ? hold_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gcnt_q   <= '0;
      lcnt_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      hold_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      lcnt_q   <= lcnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      hold_q   <= hold_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.data_gnt_o    = gnt;
  assign bus.data_rvalid_o = rvalid_q;
  assign bus.data_rdata_o  = rdata_q;
  assign read_count_o      = rd_cnt_q;
  assign write_count_o     = wr_cnt_q;

endmodule

// File: tb/tb_enokida_mem_responder.sv
// tb/tb_enokida_mem_responder.sv - directed bench for enokida_mem_responder
//   dut_a : GNT_DELAY=0, READ_LATENCY=1
//   dut_b : GNT_DELAY=2, READ_LATENCY=3
module tb_enokida_mem_responder;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic [31:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  enokida_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) a_if ();
  enokida_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) b_if ();

  enokida_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS_LOG2(10),
    .GNT_DELAY(0), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(a_if),
    .read_count_o(rd_cnt_a), .write_count_o(wr_cnt_a)
  );

  enokida_mem_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS_LOG2(10),
    .GNT_DELAY(2), .READ_LATENCY(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(b_if),
    .read_count_o(rd_cnt_b), .write_count_o(wr_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic req, input logic we, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    a_if.data_req_i   = req;
    a_if.data_we_i    = we;
    a_if.data_addr_i  = addr;
    a_if.data_be_i    = be;
    a_if.data_wdata_i = wd;
  endtask

  task automatic b_drive(input logic req, input logic we, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    b_if.data_req_i   = req;
    b_if.data_we_i    = we;
    b_if.data_addr_i  = addr;
    b_if.data_be_i    = be;
    b_if.data_wdata_i = wd;
  endtask

  // dut_a: grant in the request cycle, response in the next.
  task automatic a_txn(input logic we, input logic [15:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp, input string tag);
    a_drive(1'b1, we, addr, be, wd);
    @(negedge clk);
    check({tag, "_gnt"}, a_if.data_gnt_o, 1);
    check({tag, "_rv0"}, a_if.data_rvalid_o, 0);
    check({tag, "_rd0"}, a_if.data_rdata_o, 0);
    tick();
    a_drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    @(negedge clk);
    check({tag, "_rv1"}, a_if.data_rvalid_o, 1);
    check({tag, "_rdata"}, a_if.data_rdata_o, exp);
    tick();
  endtask

  // dut_b read from idle: gnt in cycle 2, rvalid in cycle 5.
  task automatic b_read(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    b_drive(1'b1, 1'b0, addr, 4'hF, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("%s_gnt_c%0d", tag, c), b_if.data_gnt_o, (c == 2) ? 1 : 0);
      check($sformatf("%s_rv_c%0d", tag, c), b_if.data_rvalid_o, (c == 5) ? 1 : 0);
      if (c == 5) check({tag, "_rdata"}, b_if.data_rdata_o, exp);
      tick();
      if (c == 2) b_drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    a_drive(1'b1, 1'b0, 16'h0, 4'hF, 32'h0);
    b_drive(1'b1, 1'b0, 16'h0, 4'hF, 32'h0);
    #3;
    check("rst_gnt_a", a_if.data_gnt_o, 0);
    check("rst_gnt_b", b_if.data_gnt_o, 0);
    check("rst_rv_a", a_if.data_rvalid_o, 0);
    check("rst_rd_a", a_if.data_rdata_o, 0);
    check("rst_rcnt_a", rd_cnt_a, 0);
    check("rst_wcnt_a", wr_cnt_a, 0);
    a_drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    b_drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    tick();
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // ---- dut_a: basic write / read / byte enables / wrap ----
    a_txn(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 32'h0, "a_w10");
    check("a_wcnt1", wr_cnt_a, 1);
    a_txn(1'b0, 16'h0010, 4'hF, 32'h0, 32'hDEADBEEF, "a_r10");
    a_txn(1'b0, 16'h0013, 4'h0, 32'h0, 32'hDEADBEEF, "a_r13");
    a_txn(1'b1, 16'h0010, 4'b0001, 32'h000000AA, 32'h0, "a_wbe");
    a_txn(1'b0, 16'h0010, 4'hF, 32'h0, 32'hDEADBEAA, "a_rbe");
    a_txn(1'b1, 16'h1000, 4'hF, 32'h12345678, 32'h0, "a_w1000");
    a_txn(1'b0, 16'h0000, 4'hF, 32'h0, 32'h12345678, "a_rwrap");
    check("a_rcnt4", rd_cnt_a, 4);
    check("a_wcnt3", wr_cnt_a, 3);

    // ---- dut_a: write granted in a RESP cycle leaves the read data alone ----
    a_txn(1'b1, 16'h0020, 4'hF, 32'h00000055, 32'h0, "a_w20");
    a_drive(1'b1, 1'b0, 16'h0020, 4'hF, 32'h0);
    @(negedge clk);
    check("a_b2b_gnt_r", a_if.data_gnt_o, 1);
    tick();
    a_drive(1'b1, 1'b1, 16'h0020, 4'hF, 32'h00000066);
    @(negedge clk);
    check("a_b2b_gnt_w", a_if.data_gnt_o, 1);
    check("a_b2b_rv_r", a_if.data_rvalid_o, 1);
    check("a_b2b_rd_r", a_if.data_rdata_o, 32'h00000055);
    tick();
    a_drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("a_b2b_rv_w", a_if.data_rvalid_o, 1);
    check("a_b2b_rd_w", a_if.data_rdata_o, 0);
    tick();
    a_txn(1'b0, 16'h0020, 4'hF, 32'h0, 32'h00000066, "a_r20");
    check("a_rcnt6", rd_cnt_a, 6);
    check("a_wcnt5", wr_cnt_a, 5);

    // ---- dut_b: grant delay and latency with req held continuously ----
    b_drive(1'b1, 1'b1, 16'h0040, 4'hF, 32'hCAFEF00D);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("b_hold_gnt_c%0d", c), b_if.data_gnt_o, (c == 2 || c == 7) ? 1 : 0);
      check($sformatf("b_hold_rv_c%0d", c), b_if.data_rvalid_o, (c == 5) ? 1 : 0);
      if (c == 5) check("b_hold_rd_c5", b_if.data_rdata_o, 0);
      tick();
    end
    b_drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    for (int c = 8; c < 11; c++) begin
      @(negedge clk);
      check($sformatf("b_hold_rv_c%0d", c), b_if.data_rvalid_o, (c == 10) ? 1 : 0);
      tick();
    end
    check("b_wcnt2", wr_cnt_b, 2);
    b_read(16'h0040, 32'hCAFEF00D, "b_r40");
    check("b_rcnt1", rd_cnt_b, 1);

    // ---- dut_b: reset between read grant and rvalid drops the response ----
    b_drive(1'b1, 1'b0, 16'h0040, 4'hF, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("b_rst_gnt_c%0d", c), b_if.data_gnt_o, (c == 2) ? 1 : 0);
      tick();
    end
    b_drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    #2;
    rst_b = 1'b0;
    b_if.data_req_i = 1'b1;
    @(negedge clk);
    check("b_inrst_gnt", b_if.data_gnt_o, 0);
    check("b_inrst_rv", b_if.data_rvalid_o, 0);
    check("b_inrst_rcnt", rd_cnt_b, 0);
    check("b_inrst_wcnt", wr_cnt_b, 0);
    b_if.data_req_i = 1'b0;
    tick();
    rst_b = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("b_postrst_rv_%0d", c), b_if.data_rvalid_o, 0);
      tick();
    end
    check("b_postrst_rcnt", rd_cnt_b, 0);
    b_read(16'h0040, 32'hCAFEF00D, "b_keep");
    check("b_rcnt_after", rd_cnt_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
